// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Frame parser behind the UART receiver. Assembles packets of the form
//   SYNC, OP, LEN, PAYLOAD[LEN], CHK, where CHK is the XOR of OP, LEN and
//   every payload byte. A packet that passes all checks is held for the
//   command decoder until it is accepted through a valid/ready handshake.
//
// Ports
//   i_Clock, i_Reset      clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte    one-cycle byte strobe and byte from the receiver
//   i_Cmd_Ready           decoder accepts the held command
//   i_Pl_Addr, o_Pl_Data  combinational payload buffer read port
//   o_Cmd_Valid/Op/Len    held command
//   o_Busy                parser is anywhere other than hunting for SYNC
//   o_Err_Chk/Len/Timeout one-cycle error pulses
//   o_Drop                one-cycle pulse when a byte is discarded in HOLD
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 86_999
) (
    input  logic                                            i_Clock,
    input  logic                                            i_Reset,
    input  logic                                            i_Rx_DV,
    input  logic [7:0]                                      i_Rx_Byte,
    input  logic                                            i_Cmd_Ready,
    input  logic [$clog2(MAX_LEN > 1 ? MAX_LEN : 2)-1:0]    i_Pl_Addr,
    output logic [7:0]                                      o_Pl_Data,
    output logic                                            o_Cmd_Valid,
    output logic [7:0]                                      o_Cmd_Op,
    output logic [7:0]                                      o_Cmd_Len,
    output logic                                            o_Busy,
    output logic                                            o_Err_Chk,
    output logic                                            o_Err_Len,
    output logic                                            o_Err_Timeout,
    output logic                                            o_Drop
);

    localparam int         AW       = $clog2(MAX_LEN > 1 ? MAX_LEN : 2);
    localparam int         TW       = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        HUNT, OP, LEN, PAYLOAD, CHK, HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_to_q, err_to_d;
    logic          drop_q, drop_d;
    logic          wr_en;

    logic [7:0]    mem [MAX_LEN];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        len_d     = len_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        drop_d    = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            HUNT: begin
                // counter held at zero so OP always starts a fresh window
                cnt_d = '0;
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = OP;
            end
            OP: if (i_Rx_DV) begin
                op_d    = i_Rx_Byte;
                chk_d   = i_Rx_Byte;
                state_d = LEN;
            end
            LEN: if (i_Rx_DV) begin
                len_d = i_Rx_Byte;
                chk_d = chk_q ^ i_Rx_Byte;
                if (i_Rx_Byte > MAX_LEN8) begin
                    err_len_d = 1'b1;
                    state_d   = HUNT;
                end else if (i_Rx_Byte == 8'd0) begin
                    state_d = CHK;
                end else begin
                    idx_d   = 8'd0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (i_Rx_DV) begin
                wr_en = 1'b1;
                chk_d = chk_q ^ i_Rx_Byte;
                idx_d = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) state_d = CHK;
            end
            CHK: if (i_Rx_DV) begin
                // a bad checksum byte is consumed here, never re-hunted as SYNC
                if (i_Rx_Byte == chk_q) state_d = HOLD;
                else begin
                    err_chk_d = 1'b1;
                    state_d   = HUNT;
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (i_Rx_DV) drop_d = 1'b1;
                if (valid_q && i_Cmd_Ready) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase

        // Inter-byte timeout; a strobe on the expiry cycle wins.
        if (state_q inside {OP, LEN, PAYLOAD, CHK}) begin
            if (i_Rx_DV) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                cnt_d    = '0;
                err_to_d = 1'b1;
                state_d  = HUNT;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end

        valid_d = (state_d == HOLD);
        busy_d  = (state_d != HUNT);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= HUNT;
            op_q      <= 8'd0;
            len_q     <= 8'd0;
            chk_q     <= 8'd0;
            idx_q     <= 8'd0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            drop_q    <= drop_d;
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge i_Clock) begin
        if (wr_en && !i_Reset) mem[idx_q[AW-1:0]] <= i_Rx_Byte;
    end

    assign o_Pl_Data     = (32'(i_Pl_Addr) < MAX_LEN) ? mem[i_Pl_Addr] : 8'h00;
    assign o_Cmd_Valid   = valid_q;
    assign o_Cmd_Op      = op_q;
    assign o_Cmd_Len     = len_q;
    assign o_Busy        = busy_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Len     = err_len_q;
    assign o_Err_Timeout = err_to_q;
    assign o_Drop        = drop_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
    localparam int T  = 20;
    localparam int ML = 16;

    logic       clk = 1'b0;
    logic       i_Reset, i_Rx_DV, i_Cmd_Ready;
    logic [7:0] i_Rx_Byte;
    logic [3:0] i_Pl_Addr;
    logic [7:0] o_Pl_Data, o_Cmd_Op, o_Cmd_Len;
    logic       o_Cmd_Valid, o_Busy, o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop;

    always #5 clk = ~clk;

    uart_cmd_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(ML), .TIMEOUT_CLKS(T)) dut (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .i_Cmd_Ready(i_Cmd_Ready), .i_Pl_Addr(i_Pl_Addr), .o_Pl_Data(o_Pl_Data),
        .o_Cmd_Valid(o_Cmd_Valid), .o_Cmd_Op(o_Cmd_Op), .o_Cmd_Len(o_Cmd_Len),
        .o_Busy(o_Busy), .o_Err_Chk(o_Err_Chk), .o_Err_Len(o_Err_Len),
        .o_Err_Timeout(o_Err_Timeout), .o_Drop(o_Drop)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the frame as a list of bytes seen since SYNC and decides
    // outcomes from the packet rules; values are what the outputs must
    // show after each clock edge.
    logic [7:0] fr[$];
    int         gap, n;
    logic [7:0] x;
    bit         infr = 0, hold = 0;
    logic [7:0] e_op = 0, e_ln = 0;
    bit         e_valid = 0, e_busy = 0, e_ec = 0, e_el = 0, e_et = 0, e_dr = 0;
    logic [7:0] mbuf[16];
    bit         mk[16];
    bit         mon_en = 0;

    initial for (int i = 0; i < 16; i++) mk[i] = 0;

    always @(posedge clk) begin
        e_ec = 0; e_el = 0; e_et = 0; e_dr = 0;
        if (i_Reset) begin
            infr = 0; hold = 0; e_op = 0; e_ln = 0;
        end else if (hold) begin
            if (i_Rx_DV) e_dr = 1;
            if (i_Cmd_Ready) hold = 0;
        end else if (infr) begin
            if (i_Rx_DV) begin
                fr.push_back(i_Rx_Byte);
                gap = 0;
                n = fr.size();
                if (n == 1) e_op = i_Rx_Byte;
                else if (n == 2) begin
                    e_ln = i_Rx_Byte;
                    if (int'(i_Rx_Byte) > ML) begin e_el = 1; infr = 0; end
                end else if (n <= 2 + int'(e_ln)) begin
                    mbuf[n-3] = i_Rx_Byte; mk[n-3] = 1;
                end else begin
                    x = 0;
                    for (int i = 0; i < n - 1; i++) x ^= fr[i];
                    if (x == i_Rx_Byte) hold = 1; else e_ec = 1;
                    infr = 0;
                end
            end else begin
                gap++;
                if (gap == T) begin e_et = 1; infr = 0; end
            end
        end else if (i_Rx_DV && i_Rx_Byte == 8'hA5) begin
            infr = 1; fr.delete(); gap = 0;
        end
        e_valid = hold;
        e_busy  = infr || hold;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", o_Cmd_Valid, e_valid);
            chk("busy", o_Busy, e_busy);
            chk("err_chk", o_Err_Chk, e_ec);
            chk("err_len", o_Err_Len, e_el);
            chk("err_timeout", o_Err_Timeout, e_et);
            chk("drop", o_Drop, e_dr);
            if (e_valid) begin
                chk("op", o_Cmd_Op, e_op);
                chk("len", o_Cmd_Len, e_ln);
            end
            if (mk[i_Pl_Addr]) chk("pl_data", o_Pl_Data, mbuf[i_Pl_Addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic dv, input logic [7:0] b);
        i_Rx_DV   = dv;
        i_Rx_Byte = b;
        i_Pl_Addr = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        i_Rx_DV = 1'b0;
    endtask

    // sends n bytes packed MSB first in v, on consecutive cycles
    task automatic send(input int nb, input logic [63:0] v);
        for (int i = nb - 1; i >= 0; i--) cyc(1'b1, v[8*i +: 8]);
    endtask

    task automatic accept();
        i_Cmd_Ready = 1'b1;
        cyc(1'b0, 8'h00);
        i_Cmd_Ready = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [3:0] a, input logic [7:0] exp);
        i_Pl_Addr = a;
        #1;
        chk(nm, o_Pl_Data, exp);
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_valid"}, o_Cmd_Valid, 0);
        chk({nm, "_busy"}, o_Busy, 0);
        chk({nm, "_errs"}, {o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop}, 0);
        chk({nm, "_op"}, o_Cmd_Op, 0);
        chk({nm, "_len"}, o_Cmd_Len, 0);
    endtask

    initial begin
        int k;
        i_Reset = 1; i_Rx_DV = 0; i_Rx_Byte = 0; i_Cmd_Ready = 0; i_Pl_Addr = 0;
        cyc(0, 0); cyc(0, 0);
        i_Reset = 0;
        all_zero("reset");
        mon_en = 1;

        // valid 3-byte packet
        send(7, 64'hA5_10_03_11_22_33_13);
        chk("p1_valid", o_Cmd_Valid, 1);
        chk("p1_op", o_Cmd_Op, 8'h10);
        chk("p1_len", o_Cmd_Len, 3);
        rd("p1_buf0", 0, 8'h11);
        rd("p1_buf1", 1, 8'h22);
        rd("p1_buf2", 2, 8'h33);
        cyc(0, 0); cyc(0, 0);
        chk("p1_still_valid", o_Cmd_Valid, 1);
        accept();
        chk("p1_acc_valid", o_Cmd_Valid, 0);
        chk("p1_acc_busy", o_Busy, 0);

        // bad checksum, then good zero-length
        send(4, 64'hA5_20_00_21);
        chk("bad_chk_pulse", o_Err_Chk, 1);
        chk("bad_chk_valid", o_Cmd_Valid, 0);
        cyc(0, 0);
        chk("bad_chk_one_cycle", o_Err_Chk, 0);
        send(4, 64'hA5_20_00_20);
        chk("zlen_valid", o_Cmd_Valid, 1);
        chk("zlen_len", o_Cmd_Len, 0);
        accept();

        // mismatching CHK byte equal to SYNC is not a new frame start
        send(4, 64'hA5_20_00_A5);
        chk("chk_a5_err", o_Err_Chk, 1);
        send(3, 64'h20_00_20);
        chk("chk_a5_no_frame", o_Busy, 0);

        // length too long; garbage before SYNC
        send(3, 64'hA5_01_11);
        chk("len_err", o_Err_Len, 1);
        chk("len_err_busy", o_Busy, 0);
        send(3, 64'h00_FF_5A);
        chk("garbage_busy", o_Busy, 0);
        send(5, 64'hA5_42_01_7E_3D);
        chk("g_valid", o_Cmd_Valid, 1);
        chk("g_op", o_Cmd_Op, 8'h42);
        accept();

        // timeout latency
        send(2, 64'hA5_01);
        k = -1;
        for (int i = 1; i <= T + 5; i++) begin
            cyc(0, 0);
            if (o_Err_Timeout === 1'b1 && k < 0) k = i;
        end
        chk("timeout_latency", k, T);
        chk("timeout_hunt", o_Busy, 0);

        // strobe on the expiry cycle suppresses the timeout
        send(2, 64'hA5_01);
        repeat (T - 1) cyc(0, 0);
        cyc(1, 8'h02);
        chk("to_suppressed", o_Err_Timeout, 0);
        chk("to_supp_busy", o_Busy, 1);
        send(3, 64'hAA_BB_12);
        chk("to_supp_valid", o_Cmd_Valid, 1);
        accept();

        // drops in HOLD, including the acceptance cycle
        send(5, 64'hA5_33_01_44_76);
        chk("h_valid", o_Cmd_Valid, 1);
        cyc(1, 8'hA5);
        chk("h_drop", o_Drop, 1);
        chk("h_op", o_Cmd_Op, 8'h33);
        chk("h_len", o_Cmd_Len, 1);
        cyc(0, 0);
        chk("h_drop_clear", o_Drop, 0);
        i_Cmd_Ready = 1;
        cyc(1, 8'h99);
        i_Cmd_Ready = 0;
        chk("h_acc_drop", o_Drop, 1);
        chk("h_acc_valid", o_Cmd_Valid, 0);

        // reset mid-payload, then a fresh packet
        send(5, 64'hA5_30_04_11_22);
        i_Reset = 1;
        cyc(0, 0);
        i_Reset = 0;
        all_zero("midreset");
        send(8, 64'hA5_30_04_01_02_03_04_30);
        chk("r_valid", o_Cmd_Valid, 1);
        chk("r_op", o_Cmd_Op, 8'h30);
        chk("r_len", o_Cmd_Len, 4);
        rd("r_buf3", 3, 8'h04);
        accept();
        repeat (3) cyc(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame parser and sequencer sitting directly behind the UART receiver. It consumes the receiver's one-cycle byte strobes and assembles framed command packets: sync byte, opcode, length, payload, XOR checksum. Each packet is validated for length, checksum and inter-byte timeout. A good command is presented to the command decoder through a valid/ready handshake, and the payload is readable from an internal buffer.

## Interface
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: maximum payload bytes; buffer depth; must be ≤ 255.
- TIMEOUT_CLKS, 86_999: inter-byte timeout in clocks (≈10 byte times at 870 clks/bit); must be ≥ 2.

- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  byte strobe from UART receiver, one cycle per byte.
- i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1.
- i_Cmd_Ready  in  1  decoder accepts the held command.
- i_Pl_Addr  in  clog2(MAX_LEN)  payload buffer read address.
- o_Pl_Data  out  8  payload byte at i_Pl_Addr; combinational read.
- o_Cmd_Valid  out  1  a checked command is held.
- o_Cmd_Op  out  8  opcode of the held command.
- o_Cmd_Len  out  8  payload length of the held command.
- o_Busy  out  1  high in any state other than HUNT.
- o_Err_Chk  out  1  one-cycle pulse on checksum mismatch.
- o_Err_Len  out  1  one-cycle pulse when LEN exceeds MAX_LEN.
- o_Err_Timeout  out  1  one-cycle pulse on inter-byte timeout.
- o_Drop  out  1  one-cycle pulse when a byte arrives in HOLD and is discarded.

## Operation
- States: HUNT, OP, LEN, PAYLOAD, CHK, HOLD.
- All state changes happen only on a cycle with i_Rx_DV=1, except timeout and handshake exits.
- HUNT:
  - A byte equal to SYNC_BYTE moves to OP.
  - Any other byte is ignored silently.
- OP:
  - Latch the byte as opcode.
  - Set running checksum to the byte.
  - Move to LEN.
- LEN:
  - Latch the byte as length.
  - XOR the byte into the checksum.
  - LEN > MAX_LEN: pulse o_Err_Len and return to HUNT.
  - LEN = 0: move to CHK.
  - Otherwise: clear the payload index and move to PAYLOAD.
- PAYLOAD:
  - Write the byte to buffer[index] and XOR it into the checksum.
  - Increment the index.
  - The byte at index LEN-1 moves to CHK.
- CHK:
  - Byte equal to the checksum: move to HOLD.
  - Byte not equal: pulse o_Err_Chk and return to HUNT.
  - A mismatching byte is never re-examined as SYNC.
- HOLD:
  - o_Cmd_Valid=1.
  - o_Cmd_Op, o_Cmd_Len and the buffer contents are stable.
  - When o_Cmd_Valid & i_Cmd_Ready are both high, return to HUNT.
  - Any i_Rx_DV in HOLD, including the acceptance cycle, pulses o_Drop; the byte is discarded.
- Timeout:
  - Applies in OP, LEN, PAYLOAD and CHK.
  - The counter clears on entry to OP and on every i_Rx_DV.
  - It increments on all other cycles.
  - When it reaches TIMEOUT_CLKS-1 with no strobe that cycle: pulse o_Err_Timeout and go to HUNT.
  - No timeout applies in HUNT or HOLD; HOLD waits indefinitely.
- Buffer:
  - Writes occur only in PAYLOAD.
  - Entries at index ≥ LEN hold stale data.
  - Reads of addresses ≥ MAX_LEN return 8'h00.
- Back-to-back strobes on consecutive cycles must be handled; no minimum spacing is assumed.

## Timing
- Reset:
  - State returns to HUNT.
  - All outputs go to 0: o_Cmd_Valid, o_Busy, all error pulses, o_Drop, o_Cmd_Op, o_Cmd_Len.
  - Checksum, index and timeout counter clear.
  - Buffer contents are not cleared.
  - Reset mid-packet or in HOLD aborts the packet with no error pulse.
- o_Cmd_Valid rises the cycle after the clock edge that samples the matching CHK byte.
- o_Cmd_Valid falls the cycle after the handshake.
- Error pulses are registered and assert in the cycle after the offending strobe or timeout edge.
- At most one of o_Err_Chk, o_Err_Len and o_Err_Timeout is high in any cycle.
- A strobe in the same cycle the timeout count would expire takes priority: the byte is processed and there is no timeout.
- o_Busy is registered from the state.
- o_Pl_Data has zero-cycle latency from i_Pl_Addr.

## Test plan
- Valid 3-byte packet:
  - Stimulus: strobes A5, 10, 03, 11, 22, 33, chk = 10^03^11^22^33 = 0x13; i_Cmd_Ready=0.
  - Response: o_Cmd_Valid=1 with Op=0x10, Len=3; buffer[0..2] = 11, 22, 33.
  - Then raise i_Cmd_Ready for one cycle: o_Cmd_Valid=0 and o_Busy=0 the next cycle.
- Bad checksum and zero length:
  - A5, 20, 00, 21 gives o_Err_Chk for one cycle, no o_Cmd_Valid.
  - A following A5, 20, 00, 20 gives o_Cmd_Valid=1 with Len=0.
- Length and hunt:
  - With MAX_LEN=16, A5, 01, 11 gives o_Err_Len.
  - Garbage 00, FF, 5A before A5 is ignored; no error pulses.
- Timeout:
  - A5, 01 then silence: o_Err_Timeout exactly TIMEOUT_CLKS cycles after the 01 strobe, then HUNT.
  - A strobe arriving on the expiry cycle suppresses the timeout.
- HOLD drop and reset:
  - A byte strobed during HOLD, and on the acceptance cycle, pulses o_Drop and leaves Op/Len unchanged.
  - i_Reset asserted mid-PAYLOAD: every output is 0 the next cycle, and a fresh packet then parses correctly.
